// File: rtl/hybrid_cache_pkg.sv
// Shared types and constants for the hybrid cache line-fill path.
// The writeback option is enabled by defining HYBRID_CACHE_WRITEBACK_EN.
package hybrid_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_LOAD,
        ST_WB_SEND,
        ST_FILL,
        ST_DONE
    } fill_state_e;

    localparam logic [1:0] WL_BYTE = 2'b00;
    localparam logic [1:0] WL_HALF = 2'b01;
    localparam logic [1:0] WL_WORD = 2'b10;

    localparam int LINE_LSBBITS = 7;

    // 4-byte words: the low two offset bits select the byte lane.
    function automatic int words_per_line(input int lsbbits);
        return 1 << (lsbbits - 2);
    endfunction

    localparam int WORDS_PER_LINE = words_per_line(LINE_LSBBITS);

endpackage

// File: rtl/hybrid_cache_word_counter.sv
// Word index counter for line transfers: sync clear, enable, terminal-count flag.
module hybrid_cache_word_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = &cnt_q;

endmodule

// File: rtl/hybrid_cache_linefill.sv
// Line-fill controller: fetches a full line from main memory into the line memory.
// Define HYBRID_CACHE_WRITEBACK_EN to drain a dirty victim line before the fill.
module hybrid_cache_linefill
    import hybrid_cache_pkg::*;
#(
    parameter int ADDRBITS    = 32,
    parameter int DATABITS    = 32,
    parameter int LSBBITS     = 7,
    parameter int WORDLENBITS = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   fill_req_i,
    input  logic [ADDRBITS-1:0]    fill_addr_i,
    input  logic                   fill_dirty_i,
    input  logic [ADDRBITS-1:0]    fill_wbaddr_i,
    output logic                   fill_busy_o,
    output logic                   fill_done_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDRBITS-1:0]    mem_addr_o,
    output logic [DATABITS-1:0]    mem_wdata_o,
    input  logic                   mem_ack_i,
    input  logic                   mem_rvalid_i,
    input  logic [DATABITS-1:0]    mem_rdata_i,
    output logic [LSBBITS-1:0]     line_mem_wraddr_o,
    output logic                   line_mem_we_o,
    output logic [DATABITS-1:0]    line_mem_in_o,
    output logic [WORDLENBITS-1:0] line_mem_in_wordlen_o,
    output logic [LSBBITS-1:0]     line_mem_rdaddr_o,
    input  logic [DATABITS-1:0]    line_mem_out_i
);

    localparam int IDXBITS  = $clog2(words_per_line(LSBBITS));
    localparam int BASEBITS = ADDRBITS - LSBBITS;

    fill_state_e         state_q, state_d;
    logic [BASEBITS-1:0] fill_base_q, fill_base_d;
    logic                iss_all_q, iss_all_d;
    logic [IDXBITS-1:0]  iss_idx, rcv_idx;
    logic                iss_tc, rcv_tc, iss_en, rcv_en, cnt_clr;

    hybrid_cache_word_counter #(.WIDTH(IDXBITS)) u_iss_cnt (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(iss_en),
        .cnt_o(iss_idx), .tc_o(iss_tc)
    );

    hybrid_cache_word_counter #(.WIDTH(IDXBITS)) u_rcv_cnt (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(rcv_en),
        .cnt_o(rcv_idx), .tc_o(rcv_tc)
    );

    logic unused_lsb;
    assign unused_lsb = ^{fill_addr_i[LSBBITS-1:0], fill_wbaddr_i[LSBBITS-1:0]};

`ifdef HYBRID_CACHE_WRITEBACK_EN
    logic [BASEBITS-1:0] wb_base_q, wb_base_d;
    logic [DATABITS-1:0] wdata_q, wdata_d, wb_wdata;
    logic                wb_first_q, wb_first_d;
    logic [IDXBITS-1:0]  wb_idx;
    logic                wb_tc, wb_en;

    hybrid_cache_word_counter #(.WIDTH(IDXBITS)) u_wb_cnt (
        .clk_i(clk_i), .reset_i(reset_i), .clr_i(cnt_clr), .en_i(wb_en),
        .cnt_o(wb_idx), .tc_o(wb_tc)
    );

    // Line memory data lands in the first send cycle; hold it while ack is stalled.
    assign wb_wdata = wb_first_q ? line_mem_out_i : wdata_q;
`else
    logic unused_wb;
    assign unused_wb = ^{fill_dirty_i, fill_wbaddr_i, line_mem_out_i};
`endif

    assign line_mem_in_wordlen_o = WORDLENBITS'(WL_WORD);
    assign fill_busy_o           = (state_q != ST_IDLE);

    always_comb begin
        state_d           = state_q;
        fill_base_d       = fill_base_q;
        iss_all_d         = iss_all_q;
        iss_en            = 1'b0;
        rcv_en            = 1'b0;
        cnt_clr           = 1'b0;
        fill_done_o       = 1'b0;
        mem_req_o         = 1'b0;
        mem_we_o          = 1'b0;
        mem_addr_o        = '0;
        mem_wdata_o       = '0;
        line_mem_we_o     = 1'b0;
        line_mem_wraddr_o = '0;
        line_mem_in_o     = '0;
        line_mem_rdaddr_o = '0;
`ifdef HYBRID_CACHE_WRITEBACK_EN
        wb_base_d         = wb_base_q;
        wdata_d           = wdata_q;
        wb_first_d        = wb_first_q;
        wb_en             = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_clr   = 1'b1;
                iss_all_d = 1'b0;
                if (fill_req_i) begin
                    fill_base_d = fill_addr_i[ADDRBITS-1:LSBBITS];
`ifdef HYBRID_CACHE_WRITEBACK_EN
                    wb_base_d = fill_wbaddr_i[ADDRBITS-1:LSBBITS];
                    state_d   = fill_dirty_i ? ST_WB_LOAD : ST_FILL;
`else
                    state_d   = ST_FILL;
`endif
                end
            end
`ifdef HYBRID_CACHE_WRITEBACK_EN
            ST_WB_LOAD: begin
                line_mem_rdaddr_o = {wb_idx, 2'b00};
                wb_first_d        = 1'b1;
                state_d           = ST_WB_SEND;
            end
            ST_WB_SEND: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {wb_base_q, wb_idx, 2'b00};
                mem_wdata_o = wb_wdata;
                wdata_d     = wb_wdata;
                wb_first_d  = 1'b0;
                if (mem_ack_i) begin
                    wb_en   = 1'b1;
                    state_d = wb_tc ? ST_FILL : ST_WB_LOAD;
                end
            end
`endif
            ST_FILL: begin
                if (!iss_all_q) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {fill_base_q, iss_idx, 2'b00};
                    if (mem_ack_i) begin
                        iss_en = 1'b1;
                        if (iss_tc)
                            iss_all_d = 1'b1;
                    end
                end
                // Returned data is never backpressured; write it straight through.
                if (mem_rvalid_i) begin
                    line_mem_we_o     = 1'b1;
                    line_mem_wraddr_o = {rcv_idx, 2'b00};
                    line_mem_in_o     = mem_rdata_i;
                    rcv_en            = 1'b1;
                    if (rcv_tc)
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                fill_done_o = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            fill_base_q <= '0;
            iss_all_q   <= 1'b0;
`ifdef HYBRID_CACHE_WRITEBACK_EN
            wb_base_q   <= '0;
            wdata_q     <= '0;
            wb_first_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fill_base_q <= fill_base_d;
            iss_all_q   <= iss_all_d;
`ifdef HYBRID_CACHE_WRITEBACK_EN
            wb_base_q   <= wb_base_d;
            wdata_q     <= wdata_d;
            wb_first_q  <= wb_first_d;
`endif
        end
    end

endmodule

// File: tb/tb_hybrid_cache_linefill.sv
// Scoreboard bench for hybrid_cache_linefill with a main-memory responder and line-memory model.
module tb_hybrid_cache_linefill;

    logic        clk = 1'b0;
    logic        reset, fill_req, fill_dirty, mem_ack, mem_rvalid;
    logic [31:0] fill_addr, fill_wbaddr, mem_rdata, line_mem_out;
    logic        fill_busy, fill_done, mem_req, mem_we, line_mem_we;
    logic [31:0] mem_addr, mem_wdata, line_mem_in;
    logic [6:0]  line_mem_wraddr, line_mem_rdaddr;
    logic [1:0]  line_mem_in_wordlen;

    hybrid_cache_linefill dut (
        .clk_i(clk), .reset_i(reset), .fill_req_i(fill_req), .fill_addr_i(fill_addr),
        .fill_dirty_i(fill_dirty), .fill_wbaddr_i(fill_wbaddr), .fill_busy_o(fill_busy),
        .fill_done_o(fill_done), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .line_mem_wraddr_o(line_mem_wraddr), .line_mem_we_o(line_mem_we),
        .line_mem_in_o(line_mem_in), .line_mem_in_wordlen_o(line_mem_in_wordlen),
        .line_mem_rdaddr_o(line_mem_rdaddr), .line_mem_out_i(line_mem_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line memory: write port from the DUT, registered read port, bulk preload.
    logic [31:0] lm [32];
    logic        lm_init = 1'b0;
    logic [31:0] lm_init_base = 32'h0;
    always @(posedge clk) begin
        if (lm_init) begin
            for (int i = 0; i < 32; i++) lm[i] <= lm_init_base + 32'(i);
        end else if (line_mem_we) begin
            lm[line_mem_wraddr[6:2]] <= line_mem_in;
        end
        line_mem_out <= lm[line_mem_rdaddr[6:2]];
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         fill_exp_q[$];
    wr_t         wb_exp_q[$];
    logic [31:0] pend_q[$];

    int n_chk = 0, n_pass = 0;
    int ack_pct = 100, rv_pct = 100;
    logic rv_force = 1'b0;
    logic [31:0] rd_base, salt;
    int rd_iss, we_cnt, done_cnt, done_cyc, last_we_cyc, req_cyc, mem_we_seen;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    // One cycle: drive responder inputs after the falling edge, observe, cross the rising edge.
    task automatic step();
        wr_t e;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        if (rv_force) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end else if (pend_q.size() > 0 && $urandom_range(99) < rv_pct) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_q.pop_front();
        end
        mem_ack = mem_req && ($urandom_range(99) < ack_pct);
        #1;
        if (mem_we) mem_we_seen++;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                chk("wb_pending", 32'(wb_exp_q.size() != 0), 32'd1);
                if (wb_exp_q.size() != 0) begin
                    e = wb_exp_q.pop_front();
                    chk("wb_addr", mem_addr, e.addr);
                    chk("wb_data", mem_wdata, e.data);
                end
            end else begin
                chk("rd_addr", mem_addr, rd_base + 32'(rd_iss * 4));
                pend_q.push_back(salt + 32'(mem_addr[6:2]));
                rd_iss++;
            end
        end
        if (line_mem_we) begin
            chk("lm_pending", 32'(fill_exp_q.size() != 0), 32'd1);
            if (fill_exp_q.size() != 0) begin
                e = fill_exp_q.pop_front();
                chk("lm_addr", 32'(line_mem_wraddr), e.addr);
                chk("lm_data", line_mem_in, e.data);
            end
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (fill_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_fill(input logic [31:0] addr, input logic dirty,
                              input logic [31:0] wbaddr, input logic [31:0] s);
        rd_base = {addr[31:7], 7'b0};
        salt    = s;
        rd_iss  = 0; we_cnt = 0; done_cnt = 0; mem_we_seen = 0;
        pend_q.delete();
        for (int i = 0; i < 32; i++) fill_exp_q.push_back('{32'(i * 4), s + 32'(i)});
        fill_addr = addr; fill_dirty = dirty; fill_wbaddr = wbaddr;
        fill_req = 1'b1;
        req_cyc  = cyc;
        step();
        fill_req = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            step();
            k++;
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        reset = 1'b1; fill_req = 1'b0; fill_dirty = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
        fill_addr = '0; fill_wbaddr = '0; mem_rdata = '0;
        @(negedge clk);
        lm_init_base = 32'h5555_0000; lm_init = 1'b1;
        step(); step();
        lm_init = 1'b0;
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 32'(fill_busy), 32'd0);
        chk("rst_done", 32'(fill_done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_lmwe", 32'(line_mem_we), 32'd0);
        chk("rst_rdaddr", 32'(line_mem_rdaddr), 32'd0);
        chk("rst_wordlen", 32'(line_mem_in_wordlen), 32'd2);

        // Clean fill, ack every cycle, data = word index
        ack_pct = 100; rv_pct = 100;
        start_fill(32'h0000_1234, 1'b0, 32'h0, 32'h0);
        chk("clean_busy", 32'(fill_busy), 32'd1);
        wait_done(200);
        chk("clean_done_lat", 32'(done_cyc - req_cyc), 32'd34);
        chk("clean_lastwe_lat", 32'(last_we_cyc - req_cyc), 32'd33);
        chk("clean_we_cnt", 32'(we_cnt), 32'd32);
        step(); step(); step();
        chk("clean_idle", 32'(fill_busy), 32'd0);
        chk("clean_one_done", 32'(done_cnt), 32'd1);
        chk("clean_lm0", lm[0], 32'd0);
        chk("clean_lm31", lm[31], 32'd31);

        // Random stalls, plus a stray fill_req mid-fill
        ack_pct = 50; rv_pct = 40;
        start_fill(32'h0004_5678, 1'b0, 32'h0, 32'h0000_1000);
        for (int i = 0; i < 20; i++) step();
        fill_req = 1'b1; step(); fill_req = 1'b0;
        wait_done(2000);
        for (int i = 0; i < 40; i++) step();
        chk("rand_we_cnt", 32'(we_cnt), 32'd32);
        chk("rand_one_done", 32'(done_cnt), 32'd1);
        chk("rand_exp_empty", 32'(fill_exp_q.size()), 32'd0);
        chk("rand_no_extra_rd", 32'(rd_iss), 32'd32);
        chk("rand_lm5", lm[5], 32'h0000_1005);
        chk("rand_idle", 32'(fill_busy), 32'd0);

        // Reset after 10 received words
        ack_pct = 100; rv_pct = 100;
        start_fill(32'h0000_3000, 1'b0, 32'h0, 32'h0000_2000);
        for (int k = 0; k < 200 && we_cnt < 10; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(fill_busy), 32'd0);
        chk("abort_addr", mem_addr, 32'd0);
        fill_exp_q.delete();
        pend_q.delete();
        we_cnt = 0;
        rv_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_rvalid_we", 32'(line_mem_we), 32'd0);
        end
        rv_force = 1'b0;
        chk("late_we_cnt", 32'(we_cnt), 32'd0);
        step();

`ifdef HYBRID_CACHE_WRITEBACK_EN
        // Dirty victim drained before the fill
        lm_init_base = 32'hA5A5_0000; lm_init = 1'b1;
        step();
        lm_init = 1'b0;
        for (int i = 0; i < 32; i++) wb_exp_q.push_back('{32'h0000_8000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i)});
        ack_pct = 70; rv_pct = 80;
        start_fill(32'h0000_2000, 1'b1, 32'h0000_8000, 32'h0000_3000);
        wait_done(3000);
        chk("wb_exp_empty", 32'(wb_exp_q.size()), 32'd0);
        chk("wb_we_seen", 32'(mem_we_seen > 0), 32'd1);
        chk("wb_fill_cnt", 32'(we_cnt), 32'd32);
        step();
        chk("wb_lm31", lm[31], 32'h0000_301F);
`else
        // Dirty flag ignored: plain fill with fill latency
        ack_pct = 100; rv_pct = 100;
        start_fill(32'h0000_2000, 1'b1, 32'h0000_8000, 32'h0000_3000);
        wait_done(200);
        chk("nowb_done_lat", 32'(done_cyc - req_cyc), 32'd34);
        chk("nowb_mem_we", 32'(mem_we_seen), 32'd0);
        chk("nowb_we_cnt", 32'(we_cnt), 32'd32);
        step();
        chk("nowb_lm31", lm[31], 32'h0000_301F);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hybrid_cache_linefill.md
# hybrid_cache_linefill

Line-fill controller sitting directly upstream of the hybrid cache line memory block. On a miss it fetches one full cache line from main memory word by word and writes each returned word into the line memory with word-length writes. With the writeback option compiled in, it first drains the dirty victim line from the line memory to main memory. Handshakes with the cache control FSM via `fill_req`/`fill_done`.

## Interface
- `ADDRBITS`, 32, memory address width
- `DATABITS`, 32, data width; fixed 4 byte lanes
- `LSBBITS`, 7, byte-offset bits within a line (128-byte line, 32 words)
- `WORDLENBITS`, 2, width of line-memory word-length code

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fill_req`  in  1  start request, sampled only in IDLE
- `fill_addr`  in  ADDRBITS  miss address; bits [LSBBITS-1:0] ignored
- `fill_dirty`  in  1  victim line dirty (used only with writeback)
- `fill_wbaddr`  in  ADDRBITS  victim line address; low bits ignored
- `fill_busy`  out  1  high in every state except IDLE
- `fill_done`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  1 = write request, 0 = read
- `mem_addr`  out  ADDRBITS  word-aligned request address
- `mem_wdata`  out  DATABITS  write data
- `mem_ack`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid, in issue order
- `mem_rdata`  in  DATABITS  read data
- `line_mem_wraddr`  out  LSBBITS  byte write address, always word aligned
- `line_mem_we`  out  1  line-memory write enable
- `line_mem_in`  out  DATABITS  line-memory write data
- `line_mem_in_wordlen`  out  WORDLENBITS  constant 2'b10 (word)
- `line_mem_rdaddr`  out  LSBBITS  byte read address (writeback)
- `line_mem_out`  in  DATABITS  line-memory read data, valid one cycle after `line_mem_rdaddr`

## Operation
- States: IDLE, WB_LOAD, WB_SEND, FILL, DONE.
- IDLE: `fill_req`=1 latches line bases; go to WB_LOAD if writeback compiled in and `fill_dirty`=1, else FILL.
- WB_LOAD: drive `line_mem_rdaddr` = {wb_idx,2'b00}; next cycle latch `line_mem_out` into `mem_wdata`, go WB_SEND.
- WB_SEND: `mem_req`=1, `mem_we`=1, `mem_addr`={wb_base,wb_idx,2'b00}; hold until `mem_ack`. On ack: wb_idx+1, back to WB_LOAD; after word 31, go FILL.
- FILL: issue counter `iss_idx` and receive counter `rcv_idx` (5 bits each, 0..31). `mem_req`=1, `mem_we`=0 while `iss_idx` has not issued 32 words; `iss_idx` increments on `mem_ack`. Every `mem_rvalid` writes `mem_rdata` to `line_mem_wraddr`={rcv_idx,2'b00} with `line_mem_we`=1 in that same cycle, combinationally; `rcv_idx` increments. Multiple outstanding reads allowed; no backpressure on returned data.
- After 32nd receive: go DONE; DONE pulses `fill_done` for one cycle, returns to IDLE.
- `mem_rvalid` in IDLE/WB states or beyond 32 receives: ignored, no line write.
- `fill_req` while busy: ignored. `fill_req` held high in DONE is not seen until IDLE.

## Timing
- Reset: state IDLE; counters 0; all outputs 0 except `line_mem_in_wordlen`=2'b10.
- Reset mid-operation: abort immediately, no further requests; line contents left partially filled.
- `fill_req` at cycle n -> `mem_req` (or first `line_mem_rdaddr`) at cycle n+1.
- Fill with ack every cycle and rvalid one cycle after ack: last `line_mem_we` at n+33, `fill_done` at n+34.
- Writeback: 2 cycles/word minimum (load + send with immediate ack); 64 cycles for a full line.
- `mem_ack` and `mem_rvalid` in the same cycle: both counters advance.

## Configuration
- `HYBRID_CACHE_WRITEBACK_EN` defined: WB_LOAD/WB_SEND states, `fill_dirty` honoured.
- Undefined: WB states absent, `fill_dirty`/`fill_wbaddr`/`line_mem_out` unused, `mem_we` tied 0, `line_mem_rdaddr` tied 0.

## Structure
- `hybrid_cache_pkg`: state enum, word-length codes (BYTE 2'b00, HALF 2'b01, WORD 2'b10), words-per-line constant derived from LSBBITS.
- One sub-module natural: `hybrid_cache_word_counter` (5-bit, sync clear, enable, terminal-count flag), instanced for `iss_idx`, `rcv_idx`, `wb_idx`.

## Test plan
- Clean fill, addr 0x0000_1234, ack every cycle, rdata = word index -> 32 line writes at 0x00..0x7C, data 0..31, `fill_done` at n+34.
- Random ack/rvalid stalls -> identical line contents, strictly ascending `line_mem_wraddr`, exactly one `fill_done`.
- `fill_req` pulsed during FILL -> ignored, no second fill.
- Reset asserted after 10 received words -> outputs 0 next cycle, late `mem_rvalid` produces no `line_mem_we`.
- Writeback (macro defined), dirty victim 0x0000_8000 preloaded with 0xA5A5_0000+i -> 32 writes to 0x8000..0x807C with matching data, then fill.
- Macro undefined with `fill_dirty`=1 -> no `mem_we` ever asserted, plain fill only.
